// File: rtl/pipeline_control_pkg.sv
// pipeline_control_pkg: FSM state type, opcode and control encodings, operand-use helpers
package pipeline_control_pkg;
  typedef enum logic [1:0] {RUN, BR_WAIT, BR_RESOLVE} fsm_state_t;
  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
  localparam logic CTL_ALU_A_RS1 = 1'b0;
  localparam logic CTL_ALU_A_PC  = 1'b1;
  localparam logic CTL_ALU_B_RS2 = 1'b0;
  localparam logic CTL_ALU_B_IMM = 1'b1;
  localparam logic [1:0] CTL_ALU_ADD    = 2'd0;
  localparam logic [1:0] CTL_ALU_OP     = 2'd1;
  localparam logic [1:0] CTL_ALU_OP_IMM = 2'd2;
  localparam logic [1:0] CTL_ALU_BRANCH = 2'd3;
  localparam logic [2:0] CTL_WRITEBACK_ALU = 3'd0;
  localparam logic [2:0] CTL_WRITEBACK_MEM = 3'd1;
  localparam logic [2:0] CTL_WRITEBACK_PC4 = 3'd2;
  localparam logic [2:0] CTL_WRITEBACK_IMM = 3'd3;
  localparam logic [1:0] CTL_PC_PC4     = 2'd0;
  localparam logic [1:0] CTL_PC_PC_IMM  = 2'd1;
  localparam logic [1:0] CTL_PC_RS1_IMM = 2'd2;
  localparam logic [1:0] CTL_PC_PC4_BR  = 2'd3;
  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op == OPCODE_LUI || op == OPCODE_AUIPC || op == OPCODE_JAL);
  endfunction
  function automatic logic uses_rs2(input logic [6:0] op);
    return op == OPCODE_OP || op == OPCODE_STORE || op == OPCODE_BRANCH;
  endfunction
endpackage

// File: rtl/pipeline_flow_control_if.sv
// pipeline_flow_control_if: decode-side instruction fields and datapath control outputs
interface pipeline_flow_control_if;
  logic       inst_valid;
  logic [6:0] inst_opcode;
  logic [4:0] inst_rd;
  logic [4:0] inst_rs1;
  logic [4:0] inst_rs2;
  logic       take_branch;
  logic       want_stall;
  logic       pc_write_enable;
  logic       no_stall;
  logic       jump_start;
  logic       flush;
  logic       regfile_write_enable;
  logic       alu_operand_a_select;
  logic       alu_operand_b_select;
  logic [1:0] alu_op_type;
  logic       data_mem_read_enable;
  logic       data_mem_write_enable;
  logic [2:0] reg_writeback_select;
  logic [1:0] next_pc_select;
  logic       illegal_inst;
  logic       busy;
  modport master (
    output inst_valid, inst_opcode, inst_rd, inst_rs1, inst_rs2, take_branch, want_stall,
    input  pc_write_enable, no_stall, jump_start, flush, regfile_write_enable,
           alu_operand_a_select, alu_operand_b_select, alu_op_type, data_mem_read_enable,
           data_mem_write_enable, reg_writeback_select, next_pc_select, illegal_inst, busy
  );
  modport slave (
    input  inst_valid, inst_opcode, inst_rd, inst_rs1, inst_rs2, take_branch, want_stall,
    output pc_write_enable, no_stall, jump_start, flush, regfile_write_enable,
           alu_operand_a_select, alu_operand_b_select, alu_op_type, data_mem_read_enable,
           data_mem_write_enable, reg_writeback_select, next_pc_select, illegal_inst, busy
  );
endinterface

// File: rtl/pipeline_hazard_detect.sv
// pipeline_hazard_detect: remembers the last accepted load's rd and flags a dependent consumer
module pipeline_hazard_detect
  import pipeline_control_pkg::*;
#(
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       inst_valid,
  input  logic [6:0] opcode,
  input  logic [4:0] rd,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       accept,
  input  logic       clear,
  output logic       hazard
);
  logic       ld_valid;
  logic [4:0] ld_rd;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      ld_valid <= 1'b0;
      ld_rd    <= '0;
    end else if (clear) begin
      ld_valid <= 1'b0;
    end else if (accept) begin
      ld_valid <= opcode == OPCODE_LOAD && rd != '0;
      ld_rd    <= rd;
    end
  assign hazard = LOAD_USE_STALL && inst_valid && ld_valid &&
                  ((uses_rs1(opcode) && rs1 == ld_rd) || (uses_rs2(opcode) && rs2 == ld_rd));
endmodule

// File: rtl/pipeline_flow_control.sv
// pipeline_flow_control: opcode decode, branch/jump resolution FSM and load-use bubble control
module pipeline_flow_control
  import pipeline_control_pkg::*;
#(
  parameter int BRANCH_LATENCY = 2,
  parameter bit LOAD_USE_STALL = 1'b1
) (
  input logic clock,
  input logic reset,
  pipeline_flow_control_if.slave bus
);
  localparam int CW = $clog2(BRANCH_LATENCY + 1);
  fsm_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          hazard, bubble;
  logic [6:0]    op;
  assign op = bus.inst_opcode;
  pipeline_hazard_detect #(.LOAD_USE_STALL(LOAD_USE_STALL)) u_hazard (
    .clock(clock), .reset(reset), .inst_valid(bus.inst_valid), .opcode(op),
    .rd(bus.inst_rd), .rs1(bus.inst_rs1), .rs2(bus.inst_rs2),
    .accept(bus.no_stall && bus.inst_valid), .clear(bubble), .hazard(hazard)
  );
  // Selects follow the opcode unconditionally; only enables are gated by priority
  assign bus.alu_operand_a_select = (op == OPCODE_AUIPC || op == OPCODE_JAL) ? CTL_ALU_A_PC : CTL_ALU_A_RS1;
  assign bus.alu_operand_b_select = (op == OPCODE_OP || op == OPCODE_BRANCH) ? CTL_ALU_B_RS2 : CTL_ALU_B_IMM;
  assign bus.alu_op_type = op == OPCODE_OP ? CTL_ALU_OP : op == OPCODE_OP_IMM ? CTL_ALU_OP_IMM :
                           op == OPCODE_BRANCH ? CTL_ALU_BRANCH : CTL_ALU_ADD;
  assign bus.reg_writeback_select = op == OPCODE_LOAD ? CTL_WRITEBACK_MEM : op == OPCODE_LUI ? CTL_WRITEBACK_IMM :
                                    (op == OPCODE_JAL || op == OPCODE_JALR) ? CTL_WRITEBACK_PC4 : CTL_WRITEBACK_ALU;
  assign bus.busy = state != RUN;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    bubble = 1'b0;
    bus.pc_write_enable = 1'b0;
    bus.no_stall = 1'b0;
    bus.jump_start = 1'b0;
    bus.flush = 1'b0;
    bus.regfile_write_enable = 1'b0;
    bus.data_mem_read_enable = 1'b0;
    bus.data_mem_write_enable = 1'b0;
    bus.next_pc_select = CTL_PC_PC4;
    bus.illegal_inst = 1'b0;
    if (reset && !bus.want_stall) begin
      if (state == RUN && hazard) begin
        bubble = 1'b1;
      end else begin
        case (state)
          RUN: begin
            bus.pc_write_enable = 1'b1;
            bus.no_stall = 1'b1;
            if (bus.inst_valid)
              case (op)
                OPCODE_LOAD: begin
                  bus.regfile_write_enable = 1'b1;
                  bus.data_mem_read_enable = 1'b1;
                end
                OPCODE_STORE: bus.data_mem_write_enable = 1'b1;
                OPCODE_OP_IMM, OPCODE_AUIPC, OPCODE_OP, OPCODE_LUI: bus.regfile_write_enable = 1'b1;
                OPCODE_MISC_MEM: bus.illegal_inst = 1'b0;
                OPCODE_BRANCH, OPCODE_JAL, OPCODE_JALR: begin
                  bus.pc_write_enable = 1'b0;
                  bus.no_stall = 1'b0;
                  bus.jump_start = 1'b1;
                  cnt_n = CW'(BRANCH_LATENCY - 1);
                  state_n = BRANCH_LATENCY == 1 ? BR_RESOLVE : BR_WAIT;
                end
                default: bus.illegal_inst = 1'b1;
              endcase
          end
          BR_WAIT: begin
            cnt_n = cnt - CW'(1);
            if (cnt_n == '0) state_n = BR_RESOLVE;
          end
          BR_RESOLVE: begin
            bus.pc_write_enable = 1'b1;
            bus.no_stall = 1'b1;
            bus.flush = op != OPCODE_BRANCH || bus.take_branch;
            bus.regfile_write_enable = op != OPCODE_BRANCH;
            bus.next_pc_select = op == OPCODE_BRANCH ? (bus.take_branch ? CTL_PC_PC_IMM : CTL_PC_PC4_BR) :
                                 op == OPCODE_JALR ? CTL_PC_RS1_IMM : CTL_PC_PC_IMM;
            state_n = RUN;
          end
          default: state_n = RUN;
        endcase
      end
    end
  end
endmodule
